// File: rtl/hpm_window_detector.sv
// HPM window detector: latches a tracer counter snapshot and scans it
// one counter per cycle against a programmable threshold table.
module hpm_window_detector #(
    parameter int NUM_CNT = 32,
    parameter int CNT_W   = 64
) (
    input  logic                            clk_h,
    input  logic                            rst_h,
    input  logic [NUM_CNT-1:0][CNT_W-1:0]   HPMout,
    input  logic                            EnableDetect,
    output logic                            EndDetect,
    input  logic [1:0]                      target,
    input  logic [NUM_CNT-1:0]              cnt_mask,
    input  logic                            thr_we,
    input  logic [$clog2(NUM_CNT)-1:0]      thr_addr,
    input  logic [CNT_W-1:0]                thr_data,
    output logic                            alarm,
    output logic                            alarm_valid,
    output logic [5:0]                      score,
    output logic                            overrun,
    input  logic                            overrun_clr
);

    localparam int IW = $clog2(NUM_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state;
    logic [NUM_CNT-1:0][CNT_W-1:0]   snap;
    logic [NUM_CNT-1:0]              mask_q;
    logic [1:0]                      target_q;
    logic [IW-1:0]                   idx;
    logic [5:0]                      acc;
    logic [CNT_W-1:0]                thr [NUM_CNT];

    logic                            hit;
    logic                            last;
    logic [5:0]                      acc_nxt;

    function automatic logic rule(input logic [1:0] t, input logic [5:0] n);
        logic r;
        r = 1'b0;
        unique case (t)
            2'd0: r = (n >= 6'd1);
            2'd1: r = (n >= 6'd2);
            2'd2: r = (n >= 6'd4);
            2'd3: r = 1'b0;
        endcase
        return r;
    endfunction

    // Current counter compare and running hit count.
    always_comb begin
        hit     = mask_q[idx] && (snap[idx] > thr[idx]);
        last    = (idx == IW'(NUM_CNT - 1));
        acc_nxt = acc + 6'(hit);
    end

    // Threshold table; a same-cycle write is seen by later compares only.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                thr[i] <= '1;
            end
        end else if (thr_we) begin
            thr[thr_addr] <= thr_data;
        end
    end

    // Sticky overrun flag; a new set beats a simultaneous clear.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            overrun <= 1'b0;
        end else if (EnableDetect && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Capture, scan and verdict sequencing with registered results.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state       <= IDLE;
            snap        <= '0;
            mask_q      <= '0;
            target_q    <= '0;
            idx         <= '0;
            acc         <= '0;
            score       <= '0;
            alarm       <= 1'b0;
            EndDetect   <= 1'b0;
            alarm_valid <= 1'b0;
        end else begin
            EndDetect   <= 1'b0;
            alarm_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (EnableDetect) begin
                        snap     <= HPMout;
                        mask_q   <= cnt_mask;
                        target_q <= target;
                        idx      <= '0;
                        acc      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    acc <= acc_nxt;
                    if (last) begin
                        state       <= DONE;
                        score       <= acc_nxt;
                        alarm       <= rule(target_q, acc_nxt);
                        EndDetect   <= 1'b1;
                        alarm_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpm_window_detector.sv
// Self-checking bench for hpm_window_detector: directed cases plus
// randomized scans checked against a counting reference model.
module tb_hpm_window_detector;

    localparam int N = 32;
    localparam int W = 64;

    typedef logic [N-1:0][W-1:0] snap_t;

    logic          clk_h = 1'b0;
    logic          rst_h;
    snap_t         HPMout;
    logic          EnableDetect;
    logic          EndDetect;
    logic [1:0]    target;
    logic [N-1:0]  cnt_mask;
    logic          thr_we;
    logic [4:0]    thr_addr;
    logic [W-1:0]  thr_data;
    logic          alarm;
    logic          alarm_valid;
    logic [5:0]    score;
    logic          overrun;
    logic          overrun_clr;

    logic [W-1:0]  thr_m [N];
    int            n_chk = 0;
    int            n_err = 0;

    hpm_window_detector #(.NUM_CNT(N), .CNT_W(W)) dut (
        .clk_h        (clk_h),
        .rst_h        (rst_h),
        .HPMout       (HPMout),
        .EnableDetect (EnableDetect),
        .EndDetect    (EndDetect),
        .target       (target),
        .cnt_mask     (cnt_mask),
        .thr_we       (thr_we),
        .thr_addr     (thr_addr),
        .thr_data     (thr_data),
        .alarm        (alarm),
        .alarm_valid  (alarm_valid),
        .score        (score),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    function automatic int m_score(input snap_t s, input logic [N-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i] && (s[i] > thr_m[i])) n++;
        end
        return n;
    endfunction

    function automatic logic m_alarm(input logic [1:0] t, input int n);
        case (t)
            2'd0:    return n >= 1;
            2'd1:    return n >= 2;
            2'd2:    return n >= 4;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic m_reset_thr();
        for (int i = 0; i < N; i++) thr_m[i] = '1;
    endtask

    task automatic wr_thr(input int a, input logic [W-1:0] d);
        thr_we   = 1'b1;
        thr_addr = 5'(a);
        thr_data = d;
        tick();
        thr_we   = 1'b0;
        thr_m[a] = d;
    endtask

    // Start a scan, then watch a fixed window; lat counts edges since
    // the pulse was raised, so lat = j+1 is the cycle comparing counter j.
    task automatic run_scan(input snap_t s, input logic [N-1:0] m,
                            input logic [1:0] t, input bit scr,
                            input int wr_lat, input int wa,
                            input logic [W-1:0] wd, input int en_lat,
                            input int clr_lat, input int rst_lat,
                            output int first, output int pulses,
                            output logic [5:0] sc, output logic al);
        int lat;
        HPMout       = s;
        cnt_mask     = m;
        target       = t;
        EnableDetect = 1'b1;
        tick();
        EnableDetect = 1'b0;
        if (scr) for (int i = 0; i < N; i++) HPMout[i] = rnd64();
        first  = -1;
        pulses = 0;
        sc     = 'x;
        al     = 1'bx;
        lat    = 1;
        while (lat <= 45) begin
            if (EndDetect) begin
                pulses++;
                if (first < 0) begin
                    first = lat;
                    sc    = score;
                    al    = alarm;
                end
                chk("alarm_valid", 64'(alarm_valid), 64'd1);
            end
            if (lat == wr_lat) begin
                thr_we   = 1'b1;
                thr_addr = 5'(wa);
                thr_data = wd;
            end
            if (lat == en_lat)  EnableDetect = 1'b1;
            if (lat == clr_lat) overrun_clr  = 1'b1;
            if (lat == rst_lat) rst_h        = 1'b1;
            tick();
            lat++;
            thr_we       = 1'b0;
            EnableDetect = 1'b0;
            overrun_clr  = 1'b0;
            rst_h        = 1'b0;
            if (scr) for (int i = 0; i < N; i++) HPMout[i] = rnd64();
        end
    endtask

    initial begin
        snap_t       s;
        logic [N-1:0] m;
        logic [1:0]  t;
        int          first;
        int          pulses;
        int          exp_sc;
        logic [5:0]  sc;
        logic        al;

        rst_h        = 1'b1;
        HPMout       = '0;
        EnableDetect = 1'b0;
        target       = 2'd0;
        cnt_mask     = '0;
        thr_we       = 1'b0;
        thr_addr     = '0;
        thr_data     = '0;
        overrun_clr  = 1'b0;
        m_reset_thr();
        repeat (3) tick();
        rst_h = 1'b0;
        tick();

        chk("rst_end", 64'(EndDetect), 64'd0);
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_valid", 64'(alarm_valid), 64'd0);
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Reset thresholds: nothing can hit, even all-ones counters.
        for (int i = 0; i < N; i++) s[i] = (i % 2 == 0) ? '1 : rnd64();
        run_scan(s, '1, 2'd0, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("t1_lat", 64'(first), 64'd33);
        chk("t1_pulses", 64'(pulses), 64'd1);
        chk("t1_score", 64'(sc), 64'd0);
        chk("t1_alarm", 64'(al), 64'd0);

        // Strict compare: 101 > 100 hits, 5 > 5 does not.
        wr_thr(3, 64'd100);
        wr_thr(7, 64'd5);
        s    = '0;
        s[3] = 64'd101;
        s[7] = 64'd5;
        run_scan(s, '1, 2'd0, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("t2_score", 64'(sc), 64'd1);
        chk("t2_alarm", 64'(al), 64'd1);

        // Masked window of four hits under different rules.
        for (int i = 0; i < 4; i++) wr_thr(i, 64'd0);
        for (int i = 0; i < N; i++) s[i] = 64'd1;
        run_scan(s, 32'h0000_000F, 2'd2, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("t3_score_t2", 64'(sc), 64'd4);
        chk("t3_alarm_t2", 64'(al), 64'd1);
        run_scan(s, 32'h0000_000F, 2'd3, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("t3_score_t3", 64'(sc), 64'd4);
        chk("t3_alarm_t3", 64'(al), 64'd0);
        run_scan(s, 32'h0000_000F, 2'd2, 1'b1, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("t3_score_scramble", 64'(sc), 64'd4);
        chk("t3_lat_scramble", 64'(first), 64'd33);

        // Second start ten cycles into a scan.
        run_scan(s, 32'h0000_000F, 2'd1, 1'b0, -1, 0, '0, 11, -1, -1,
                 first, pulses, sc, al);
        chk("ovr_pulses", 64'(pulses), 64'd1);
        chk("ovr_lat", 64'(first), 64'd33);
        chk("ovr_score", 64'(sc), 64'd4);
        chk("ovr_set", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);

        // Set and clear in the same cycle: set wins.
        run_scan(s, 32'h0000_000F, 2'd1, 1'b0, -1, 0, '0, 11, 11, -1,
                 first, pulses, sc, al);
        chk("ovr_set_wins", 64'(overrun), 64'd1);

        // Reset during scan cycle 15 aborts everything.
        run_scan(s, 32'h0000_000F, 2'd2, 1'b0, -1, 0, '0, -1, -1, 16,
                 first, pulses, sc, al);
        m_reset_thr();
        chk("abort_pulses", 64'(pulses), 64'd0);
        chk("abort_score", 64'(score), 64'd0);
        chk("abort_alarm", 64'(alarm), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        run_scan(s, '1, 2'd0, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("fresh_lat", 64'(first), 64'd33);
        chk("fresh_score", 64'(sc), 64'd0);

        // Write to thr[20] in the cycle counter 20 is compared.
        s     = '0;
        s[20] = 64'd1;
        run_scan(s, '1, 2'd0, 1'b0, 21, 20, 64'd0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("wr_same_score", 64'(sc), 64'd0);
        chk("wr_same_alarm", 64'(al), 64'd0);
        thr_m[20] = 64'd0;
        run_scan(s, '1, 2'd0, 1'b0, -1, 0, '0, -1, -1, -1,
                 first, pulses, sc, al);
        chk("wr_next_score", 64'(sc), 64'd1);
        chk("wr_next_alarm", 64'(al), 64'd1);

        // Randomized scans against the reference model.
        for (int it = 0; it < 24; it++) begin
            int k;
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 1) == 0)
                    wr_thr($urandom_range(0, N - 1),
                           64'($urandom_range(0, 1000)));
                else
                    wr_thr($urandom_range(0, N - 1), rnd64());
            end
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       s[i] = thr_m[i] - 64'd1;
                    1:       s[i] = thr_m[i];
                    2:       s[i] = thr_m[i] + 64'd1;
                    default: s[i] = rnd64();
                endcase
            end
            m      = $urandom;
            t      = 2'($urandom_range(0, 3));
            exp_sc = m_score(s, m);
            run_scan(s, m, t, 1'($urandom_range(0, 1)), -1, 0, '0,
                     -1, -1, -1, first, pulses, sc, al);
            chk("rnd_lat", 64'(first), 64'd33);
            chk("rnd_pulses", 64'(pulses), 64'd1);
            chk("rnd_score", 64'(sc), 64'(exp_sc));
            chk("rnd_alarm", 64'(al), 64'(m_alarm(t, exp_sc)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
